// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four byte sources.
// Accepts a byte via valid/ready, pulses the transmit request, then times the frame plus guard gap.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FRAME_BITS   = 10,
  parameter int GUARD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic [7:0]  tx_data,
  output logic        tx_transmit,
  output logic        busy,
  output logic [1:0]  grant_id
);

  localparam int FRAME_CYCLES = FRAME_BITS * CLKS_PER_BIT + GUARD_CYCLES;
  localparam int CNT_W        = $clog2(FRAME_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_transmit_q, tx_transmit_d;
  logic             busy_q, busy_d;
  logic [1:0]       grant_id_q, grant_id_d;
  logic [1:0]       last_grant_q, last_grant_d;

  logic             found;
  logic [1:0]       grant_idx;
  logic [1:0]       scan_idx;

  // Scan starts just past the previous winner; reset also masks the grant.
  always_comb begin
    found     = 1'b0;
    grant_idx = 2'd0;
    scan_idx  = 2'd0;
    if (reset && state_q == IDLE) begin
      for (int k = 1; k <= 4; k++) begin
        scan_idx = last_grant_q + 2'(k);
        if (!found && req_valid[scan_idx]) begin
          found     = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
  end

  always_comb begin
    req_ready = 4'b0000;
    if (found) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tx_data_d     = tx_data_q;
    tx_transmit_d = tx_transmit_q;
    busy_d        = busy_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          tx_data_d     = req_data[grant_idx*8 +: 8];
          grant_id_d    = grant_idx;
          last_grant_d  = grant_idx;
          tx_transmit_d = 1'b1;
          busy_d        = 1'b1;
          cnt_d         = '0;
          state_d       = SEND;
        end
      end
      // Transmit request is held a full bit time so the baud-sampled transmitter cannot miss it.
      SEND: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          tx_transmit_d = 1'b0;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(FRAME_CYCLES - 1)) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tx_data_q     <= 8'h00;
      tx_transmit_q <= 1'b0;
      busy_q        <= 1'b0;
      grant_id_q    <= 2'd0;
      last_grant_q  <= 2'd3;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tx_data_q     <= tx_data_d;
      tx_transmit_q <= tx_transmit_d;
      busy_q        <= busy_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_transmit = tx_transmit_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scenario bench for uart_tx_arbiter with a grant scoreboard checked at each frame start.
module tb_uart_tx_arbiter;

  localparam int CPB   = 4;
  localparam int FB    = 10;
  localparam int GC    = 2;
  localparam int FRAME = FB * CPB + GC;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  reqValid = 4'b0000;
  logic [31:0] reqData = 32'h0;
  logic [3:0]  reqReady;
  logic [7:0]  txData;
  logic        txTransmit;
  logic        busy;
  logic [1:0]  grantId;

  int   nChecks = 0;
  int   nPass = 0;
  int   cyc = 0;
  exp_t expQ[$];
  logic prevTx = 1'b0;

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB), .FRAME_BITS(FB), .GUARD_CYCLES(GC)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(reqValid),
    .req_data(reqData),
    .req_ready(reqReady),
    .tx_data(txData),
    .tx_transmit(txTransmit),
    .busy(busy),
    .grant_id(grantId)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every frame start must match the next grant the scenarios predicted.
  always @(negedge clk) begin
    if (txTransmit === 1'b1 && prevTx !== 1'b1) begin
      nChecks++;
      if (expQ.size() == 0) begin
        $display("[TB] FAIL scoreboard_unexpected: got id=%0d data=%h, required no frame", grantId, txData);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if ({grantId, txData} !== e)
          $display("[TB] FAIL scoreboard_grant: got id=%0d data=%h, required id=%0d data=%h",
                   grantId, txData, e.id, e.data);
        else
          nPass++;
      end
    end
    prevTx = txTransmit;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic waitStart(output bit ok);
    logic prev;
    prev = txTransmit;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txTransmit === 1'b1 && prev !== 1'b1) begin
        ok = 1'b1;
        break;
      end
      prev = txTransmit;
    end
  endtask

  task automatic waitIdle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    reqData = 32'hDEADBEEF;
    reqValid = 4'b1111;
    repeat (2) @(negedge clk);
    nChecks++; if (txData !== 8'h00) $display("[TB] FAIL reset_tx_data: got %h, required 00", txData); else nPass++;
    nChecks++; if (txTransmit !== 1'b0) $display("[TB] FAIL reset_tx_transmit: got %b, required 0", txTransmit); else nPass++;
    nChecks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b, required 0", busy); else nPass++;
    nChecks++; if (grantId !== 2'd0) $display("[TB] FAIL reset_grant_id: got %0d, required 0", grantId); else nPass++;
    nChecks++; if (reqReady !== 4'b0000) $display("[TB] FAIL reset_ready: got %b, required 0000", reqReady); else nPass++;
    reqValid = 4'b0000;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    int txCnt, busyCnt;
    reqData = 32'h0;
    reqData[23:16] = 8'hA5;
    reqValid = 4'b0100;
    expQ.push_back({2'd2, 8'hA5});
    #1;
    nChecks++; if (reqReady !== 4'b0100) $display("[TB] FAIL single_ready: got %b, required 0100", reqReady); else nPass++;
    waitStart(ok);
    reqValid = 4'b0000;
    nChecks++; if (!ok) $display("[TB] FAIL single_start: got no frame start, required start"); else nPass++;
    nChecks++; if (grantId !== 2'd2 || txData !== 8'hA5)
      $display("[TB] FAIL single_outputs: got id=%0d data=%h, required id=2 data=a5", grantId, txData); else nPass++;
    #1;
    nChecks++; if (reqReady !== 4'b0000) $display("[TB] FAIL single_ready_busy: got %b, required 0000", reqReady); else nPass++;
    txCnt = 1;
    busyCnt = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      busyCnt++;
      if (txTransmit === 1'b1) txCnt++;
    end
    nChecks++; if (txCnt != CPB) $display("[TB] FAIL single_tx_len: got %0d, required %0d", txCnt, CPB); else nPass++;
    nChecks++; if (busyCnt != FRAME) $display("[TB] FAIL single_busy_len: got %0d, required %0d", busyCnt, FRAME); else nPass++;
    nChecks++; if (grantId !== 2'd2 || txData !== 8'hA5)
      $display("[TB] FAIL single_hold_idle: got id=%0d data=%h, required id=2 data=a5", grantId, txData); else nPass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int starts[5];
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    reqData = 32'h13121110;
    reqValid = 4'b1111;
    expQ.push_back({2'd0, 8'h10});
    expQ.push_back({2'd1, 8'h11});
    expQ.push_back({2'd2, 8'h12});
    expQ.push_back({2'd3, 8'h13});
    expQ.push_back({2'd0, 8'h10});
    for (int f = 0; f < 5; f++) begin
      waitStart(ok);
      starts[f] = cyc;
      nChecks++; if (!ok) $display("[TB] FAIL rr_start%0d: got no frame start, required start", f); else nPass++;
    end
    reqValid = 4'b0000;
    for (int f = 1; f < 5; f++) begin
      nChecks++;
      if (starts[f] - starts[f-1] != FRAME + 1)
        $display("[TB] FAIL rr_spacing%0d: got %0d, required %0d", f, starts[f] - starts[f-1], FRAME + 1);
      else nPass++;
    end
    waitIdle(ok);
  endtask

  task automatic test_rotation();
    bit ok;
    reqData = 32'h0;
    reqData[15:8] = 8'h21;
    reqValid = 4'b0010;
    expQ.push_back({2'd1, 8'h21});
    waitStart(ok);
    reqValid = 4'b0000;
    reqData[31:24] = 8'h3C;
    reqData[7:0] = 8'h0C;
    reqValid = 4'b1001;
    expQ.push_back({2'd3, 8'h3C});
    expQ.push_back({2'd0, 8'h0C});
    #1;
    nChecks++; if (reqReady !== 4'b0000) $display("[TB] FAIL rot_ready_busy: got %b, required 0000", reqReady); else nPass++;
    waitStart(ok);
    nChecks++; if (!ok || grantId !== 2'd3) $display("[TB] FAIL rot_first: got id=%0d ok=%0d, required id=3", grantId, ok); else nPass++;
    reqValid = 4'b0001;
    waitStart(ok);
    nChecks++; if (!ok || grantId !== 2'd0) $display("[TB] FAIL rot_second: got id=%0d ok=%0d, required id=0", grantId, ok); else nPass++;
    reqValid = 4'b0000;
    waitIdle(ok);
  endtask

  task automatic test_late_arrival();
    bit ok, bad, idleSeen;
    reqData = 32'h0;
    reqData[23:16] = 8'h2B;
    reqValid = 4'b0100;
    expQ.push_back({2'd2, 8'h2B});
    waitStart(ok);
    reqValid = 4'b0000;
    repeat (10) @(negedge clk);
    nChecks++; if (busy !== 1'b1 || txTransmit !== 1'b0)
      $display("[TB] FAIL late_in_wait: got busy=%b tx=%b, required busy=1 tx=0", busy, txTransmit); else nPass++;
    reqData[7:0] = 8'h0D;
    reqValid = 4'b0001;
    expQ.push_back({2'd0, 8'h0D});
    bad = 1'b0;
    idleSeen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        idleSeen = 1'b1;
        break;
      end
      if (reqReady !== 4'b0000) bad = 1'b1;
    end
    nChecks++; if (bad) $display("[TB] FAIL late_ready_busy: got nonzero ready, required 0000"); else nPass++;
    nChecks++; if (!idleSeen) $display("[TB] FAIL late_idle: got busy stuck, required idle"); else nPass++;
    nChecks++; if (reqReady !== 4'b0001) $display("[TB] FAIL late_first_idle_ready: got %b, required 0001", reqReady); else nPass++;
    waitStart(ok);
    nChecks++; if (!ok) $display("[TB] FAIL late_start: got no frame start, required start"); else nPass++;
    reqValid = 4'b0000;
    waitIdle(ok);
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    reqData = 32'h0;
    reqData[7:0] = 8'h5C;
    reqValid = 4'b0001;
    expQ.push_back({2'd0, 8'h5C});
    waitStart(ok);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    nChecks++; if (txTransmit !== 1'b0) $display("[TB] FAIL rstmid_tx: got %b, required 0", txTransmit); else nPass++;
    nChecks++; if (busy !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b, required 0", busy); else nPass++;
    nChecks++; if (txData !== 8'h00) $display("[TB] FAIL rstmid_data: got %h, required 00", txData); else nPass++;
    nChecks++; if (reqReady !== 4'b0000) $display("[TB] FAIL rstmid_ready_low: got %b, required 0000", reqReady); else nPass++;
    reset = 1'b1;
    expQ.push_back({2'd0, 8'h5C});
    #1;
    nChecks++; if (reqReady !== 4'b0001) $display("[TB] FAIL rstmid_ready_high: got %b, required 0001", reqReady); else nPass++;
    waitStart(ok);
    nChecks++; if (!ok) $display("[TB] FAIL rstmid_regrant: got no frame start, required start"); else nPass++;
    reqValid = 4'b0000;
    waitIdle(ok);
  endtask

  task automatic test_withdrawal();
    bit ok;
    reqData = 32'h0;
    reqData[31:24] = 8'h77;
    reqValid = 4'b1000;
    expQ.push_back({2'd3, 8'h77});
    waitStart(ok);
    reqValid = 4'b0000;
    repeat (5) @(negedge clk);
    reqData[15:8] = 8'h99;
    reqValid = 4'b0010;
    #1;
    nChecks++; if (reqReady !== 4'b0000) $display("[TB] FAIL wd_ready_busy: got %b, required 0000", reqReady); else nPass++;
    @(negedge clk);
    reqValid = 4'b0000;
    waitIdle(ok);
    nChecks++; if (!ok) $display("[TB] FAIL wd_idle: got busy stuck, required idle"); else nPass++;
    nChecks++; if (reqReady !== 4'b0000) $display("[TB] FAIL wd_ready_idle: got %b, required 0000", reqReady); else nPass++;
    repeat (5) @(negedge clk);
    nChecks++; if (txTransmit !== 1'b0 || busy !== 1'b0 || grantId !== 2'd3)
      $display("[TB] FAIL wd_no_grant: got tx=%b busy=%b id=%0d, required tx=0 busy=0 id=3",
               txTransmit, busy, grantId); else nPass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_rotation();
    test_late_arrival();
    test_reset_mid_frame();
    test_withdrawal();
    nChecks++;
    if (expQ.size() != 0) $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", expQ.size());
    else nPass++;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single 8-bit UART transmitter among 4 independent byte sources using round-robin arbitration.
- Accepts one byte from a requester through a valid/ready handshake.
- Drives the transmitter's data and transmit inputs, then times the full serial frame locally; the transmitter has no busy output.
- Sits between the button/debounce and sensor-style byte sources and the transmitter in the top level.

Parameters:
- CLKS_PER_BIT, 10416, clock cycles per UART bit (100 MHz / 9600 baud); must match the transmitter's baud divider.
- FRAME_BITS, 10, bits per frame (start + 8 data + stop).
- GUARD_CYCLES, 16, idle cycles appended after each frame before the next grant.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  4  bit i high = requester i has a byte pending.
- req_data  input  32  byte of requester i on bits [8i+7:8i].
- req_ready  output  4  one-hot grant strobe; a byte transfers when req_valid[i] & req_ready[i] at a rising edge.
- tx_data  output  8  byte presented to the transmitter.
- tx_transmit  output  1  transmit request to the transmitter.
- busy  output  1  high while a frame is in progress.
- grant_id  output  2  index of the requester owning the current frame.

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE; tx_data=0, tx_transmit=0, busy=0, grant_id=0.
  - Frame counter=0; last_grant=3, so requester 0 has top priority first.
  - Reset takes effect at the edge even mid-frame, aborting the frame: tx_transmit drops at that edge and no req_ready is issued.
- State IDLE:
  - req_ready is combinational (Mealy). It is one-hot for the first i with req_valid[i]=1, scanning last_grant+1, +2, +3, +4 (mod 4).
  - req_ready is all-zero when no request is pending or the state is not IDLE.
  - On the accepting edge:
    - tx_data <= req_data[i].
    - grant_id <= i and last_grant <= i.
    - tx_transmit <= 1, busy <= 1, counter <= 0, state <= SEND.
- State SEND:
  - tx_transmit stays 1 for exactly CLKS_PER_BIT cycles, which guarantees the baud-sampled transmitter sees it.
  - The counter increments every cycle.
  - When counter = CLKS_PER_BIT-1: tx_transmit <= 0, state <= WAIT.
- State WAIT:
  - The counter continues incrementing.
  - When counter = FRAME_BITS*CLKS_PER_BIT + GUARD_CYCLES - 1: busy <= 0, state <= IDLE.
  - busy is high for exactly FRAME_BITS*CLKS_PER_BIT + GUARD_CYCLES cycles per frame.
- Stability during a frame: tx_data and grant_id hold from acceptance until the next acceptance; they are not cleared in IDLE.
- Back-to-back: a new grant can occur in the first IDLE cycle. Minimum start-to-start spacing is FRAME_BITS*CLKS_PER_BIT + GUARD_CYCLES + 1 cycles.
- Fairness: with all 4 requesting continuously, grants rotate 0,1,2,3,0,… No requester waits more than 3 frames.
- Requester rules:
  - req_data[i] must stay stable while req_valid[i]=1 and it is not yet granted.
  - Dropping req_valid without a grant withdraws the request.
  - After the grant the arbiter ignores that requester's valid and data until the next IDLE.
- Simultaneous events:
  - A new req_valid rising during SEND/WAIT waits; it is not dropped.
  - A valid deasserting on the same edge it would be granted: no transfer, and last_grant is unchanged.
- Counter width: clog2(FRAME_BITS*CLKS_PER_BIT + GUARD_CYCLES) bits. It must not wrap within a frame.

Test Plan:
(Use CLKS_PER_BIT=4, FRAME_BITS=10, GUARD_CYCLES=2.)
- Single request: req_valid=4'b0100, byte 0xA5 on bits [23:16].
  - req_ready=4'b0100 for 1 cycle.
  - tx_data=0xA5 and grant_id=2 from the next cycle.
  - tx_transmit high for 4 cycles; busy high for 42 cycles; then IDLE.
- All four requesting with bytes 0x10,0x11,0x12,0x13 held continuously:
  - Grant order 0,1,2,3,0.
  - Successive tx_transmit rising edges exactly 43 cycles apart.
- Priority rotation: after granting requester 1, requesters 0 and 3 request simultaneously -> requester 3 granted first, then 0.
- Late arrival: req_valid[0] asserted mid-WAIT of a requester-2 frame.
  - No req_ready during busy.
  - Requester 0 granted on the first IDLE cycle.
- Reset mid-frame: reset=0 for 1 cycle at SEND cycle 2.
  - Next cycle: tx_transmit=0, busy=0, tx_data=0.
  - A pending requester 0 is re-granted only after reset returns high.
- Withdrawal: req_valid[1] pulses 1 cycle while busy -> no grant to 1, and the following IDLE issues no req_ready.
